// File: rtl/counter_load_ctrl_if.sv
// counter_load_ctrl_if
// Bundles the request handshake, the status outputs and the counter-side
// control/observation signals of counter_load_ctrl.
//   req_valid/req_ready/req_value/req_runs : request handshake
//   abort                                  : cancel the running operation
//   ld_enb/data_in/count_enb               : drive the loadable counter
//   count_out/tc                           : observed counter outputs
//   busy/done/err/err_code                 : status back to the sequencer
// Modports:
//   slave  - the controller itself (takes requests, drives the counter)
//   master - the environment: sequencer plus the counter instance
interface counter_load_ctrl_if #(
    parameter int WIDTH  = 3,
    parameter int RUNS_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_value;
    logic [RUNS_W-1:0] req_runs;
    logic              abort;
    logic              ld_enb;
    logic [WIDTH-1:0]  data_in;
    logic              count_enb;
    logic [WIDTH-1:0]  count_out;
    logic              tc;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport slave (
        input  req_valid, req_value, req_runs, abort, count_out, tc,
        output req_ready, ld_enb, data_in, count_enb, busy, done, err, err_code
    );

    modport master (
        output req_valid, req_value, req_runs, abort, count_out, tc,
        input  req_ready, ld_enb, data_in, count_enb, busy, done, err, err_code
    );
endinterface

// File: rtl/counter_load_ctrl.sv
// counter_load_ctrl
// Loads a preset into an up-counter, runs it until the requested number of
// terminal counts has been observed, and checks every running cycle against
// a shadow expected value. Reports a one-cycle done pulse or a sticky error.
// Ports:
//   clk  - rising-edge clock shared with the counter
//   rst  - asynchronous active-high reset
//   bus  - counter_load_ctrl_if.slave (request, counter control/observe, status)
// Error codes: 00 none, 01 count value mismatch, 10 tc mismatch.
module counter_load_ctrl #(
    parameter int WIDTH  = 3,
    parameter int RUNS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_load_ctrl_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [WIDTH-1:0]  exp_val;   // value the counter must show this RUN cycle
    logic [WIDTH-1:0]  data_q;
    logic [RUNS_W-1:0] run_cnt;   // tc events seen so far
    logic [RUNS_W-1:0] run_tgt;   // tc events required (never 0)
    logic              err_q;
    logic [1:0]        code_q;

    logic              all_ones;
    logic [RUNS_W:0]   run_cnt_inc;

    assign all_ones    = (bus.count_out == {WIDTH{1'b1}});
    // One extra bit so the compare never wraps.
    assign run_cnt_inc = {1'b0, run_cnt} + {{RUNS_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            exp_val <= '0;
            data_q  <= '0;
            run_cnt <= '0;
            run_tgt <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        exp_val <= bus.req_value;
                        data_q  <= bus.req_value;
                        run_tgt <= (bus.req_runs == '0) ? RUNS_W'(1) : bus.req_runs;
                        run_cnt <= '0;
                        err_q   <= 1'b0;
                        code_q  <= 2'b00;
                        state   <= LOAD;
                    end
                end
                // The counter takes data_in on the edge leaving LOAD, so the
                // first RUN cycle already shows the preset.
                LOAD: state <= bus.abort ? IDLE : RUN;
                RUN: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.count_out != exp_val) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        code_q <= 2'b01;
                    end else if (bus.tc != all_ones) begin
                        state  <= IDLE;
                        err_q  <= 1'b1;
                        code_q <= 2'b10;
                    end else if (bus.tc && (run_cnt_inc == {1'b0, run_tgt})) begin
                        state <= DONE;
                    end else begin
                        exp_val <= exp_val + 1'b1;
                        if (bus.tc)
                            run_cnt <= run_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;   // DONE lasts one cycle
            endcase
        end
    end

    // All control/status outputs decode the state register only, so reset
    // drops ld_enb/count_enb immediately.
    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.ld_enb    = (state == LOAD);
    assign bus.count_enb = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.data_in   = data_q;
    assign bus.err       = err_q;
    assign bus.err_code  = code_q;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// tb_counter_load_ctrl
// Directed bench for counter_load_ctrl. A small loadable counter (with
// stuck-at and tc-kill fault knobs) stands in for the real counter. For each
// request the bench predicts, from the counter value sequence, how many RUN
// cycles occur and how the operation ends, expands that into a per-cycle
// expected trace, and a compare process checks the DUT every cycle.
module tb_counter_load_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    counter_load_ctrl_if #(.WIDTH(3), .RUNS_W(4)) bus ();

    counter_load_ctrl #(.WIDTH(3), .RUNS_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- counter stand-in ----------------
    logic [2:0] cnt;
    logic       stuck_en = 1'b0;   // counter freezes once it reaches 2
    logic       tc_kill  = 1'b0;   // tc forced low

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         cnt <= 3'd0;
        else if (bus.ld_enb)                             cnt <= bus.data_in;
        else if (bus.count_enb && !(stuck_en && cnt == 3'd2)) cnt <= cnt + 3'd1;
    end
    assign bus.count_out = cnt;
    assign bus.tc        = !tc_kill && (cnt == 3'd7);

    // ---------------- scoreboard ----------------
    typedef struct {
        bit       ld, cen, dn, bsy, er;
        bit [1:0] code;
        bit       chk_d;
        bit [2:0] d;
    } exp_t;

    exp_t     q[$];
    bit       idle_err  = 0;
    bit [1:0] idle_code = 0;
    int       total = 0, bad = 0, done_seen = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d @%0t", name, act, want, $time);
        end
    endtask

    // Outcome codes: 0 done, 1 value error, 2 tc error, 3 abort.
    function automatic void predict(input int v, input int r, input bit st,
                                    input bit tk, input int ab,
                                    output int n, output int oc);
        int c, hits, tgt;
        c = v; hits = 0; tgt = (r == 0) ? 1 : r; n = 0; oc = 4;
        for (int k = 0; k < 64; k++) begin
            int e;
            bit t;
            e = (v + k) % 8;
            t = !tk && (c == 7);
            n = k + 1;
            if (k == ab)       begin oc = 3; return; end
            if (c != e)        begin oc = 1; return; end
            if (t != (c == 7)) begin oc = 2; return; end
            if (t) begin
                hits++;
                if (hits == tgt) begin oc = 0; return; end
            end
            if (!(st && c == 2)) c = (c + 1) % 8;
        end
    endfunction

    task automatic push_idle(input bit er, input bit [1:0] code);
        exp_t e;
        e = '{ld:0, cen:0, dn:0, bsy:0, er:er, code:code, chk_d:0, d:0};
        q.push_back(e);
    endtask

    task automatic push_trace(input int v, input int n, input int oc);
        exp_t e;
        e = '{ld:1, cen:0, dn:0, bsy:1, er:0, code:0, chk_d:1, d:v[2:0]};
        q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e = '{ld:0, cen:1, dn:0, bsy:1, er:0, code:0, chk_d:0, d:0};
            q.push_back(e);
        end
        if (oc == 0) begin
            e = '{ld:0, cen:0, dn:1, bsy:1, er:0, code:0, chk_d:0, d:0};
            q.push_back(e);
        end
        idle_err  = (oc == 1) || (oc == 2);
        idle_code = (oc == 1) ? 2'b01 : (oc == 2) ? 2'b10 : 2'b00;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (q.size() > 0) e = q.pop_front();
            else e = '{ld:0, cen:0, dn:0, bsy:0, er:idle_err, code:idle_code, chk_d:0, d:0};
            chk("ld_enb",    bus.ld_enb,    e.ld);
            chk("count_enb", bus.count_enb, e.cen);
            chk("done",      bus.done,      e.dn);
            chk("busy",      bus.busy,      e.bsy);
            chk("req_ready", bus.req_ready, !e.bsy);
            chk("err",       bus.err,       e.er);
            chk("err_code",  bus.err_code,  e.code);
            if (e.chk_d) chk("data_in", bus.data_in, e.d);
            if (bus.done) done_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
        chk("drain_timeout", q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    task automatic run_req(input int v, input int r, input bit st, input bit tk,
                           input int ab, output int n, output int oc);
        stuck_en = st;
        tc_kill  = tk;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_value = v[2:0];
        bus.req_runs  = r[3:0];
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        predict(v, r, st, tk, ab, n, oc);
        push_trace(v, n, oc);
        if (ab >= 0) begin
            repeat (1 + ab) @(posedge clk);
            #1 bus.abort = 1'b1;
            @(posedge clk);
            #1 bus.abort = 1'b0;
        end
        wait_drain();
        stuck_en = 1'b0;
        tc_kill  = 1'b0;
    endtask

    initial begin
        int n, oc, d0, n1, oc1, n2, oc2;
        bus.req_valid = 1'b0;
        bus.req_value = '0;
        bus.req_runs  = '0;
        bus.abort     = 1'b0;

        // Reset state
        #12;
        chk("rst_ld_enb",    bus.ld_enb,    0);
        chk("rst_count_enb", bus.count_enb, 0);
        chk("rst_done",      bus.done,      0);
        chk("rst_err",       bus.err,       0);
        chk("rst_err_code",  bus.err_code,  0);
        chk("rst_data_in",   bus.data_in,   0);
        chk("rst_ready",     bus.req_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // value 5, one tc: RUN sees 5,6,7
        d0 = done_seen;
        run_req(5, 1, 0, 0, -1, n, oc);
        chk("model_n_5_1", n, 3);
        chk("model_oc_5_1", oc, 0);
        chk("done_count_5_1", done_seen - d0, 1);

        // value 7, two tcs: 9 RUN cycles, counter left at 0
        d0 = done_seen;
        run_req(7, 2, 0, 0, -1, n, oc);
        chk("model_n_7_2", n, 9);
        chk("done_count_7_2", done_seen - d0, 1);
        chk("cnt_after_done", bus.count_out, 0);

        // runs=0 behaves as 1
        run_req(0, 0, 0, 0, -1, n, oc);
        chk("model_n_0_0", n, 8);

        // counter stuck at 2 after loading 1 -> value mismatch
        d0 = done_seen;
        run_req(1, 1, 1, 0, -1, n, oc);
        chk("model_n_stuck", n, 3);
        chk("model_oc_stuck", oc, 1);
        chk("stuck_err", bus.err, 1);
        chk("stuck_code", bus.err_code, 1);
        chk("stuck_no_done", done_seen - d0, 0);

        // tc suppressed at 7 -> tc mismatch; next request clears err
        run_req(5, 1, 0, 1, -1, n, oc);
        chk("model_oc_tckill", oc, 2);
        chk("tckill_code", bus.err_code, 2);
        run_req(2, 1, 0, 0, -1, n, oc);
        chk("err_cleared", bus.err, 0);

        // abort on the 5th RUN cycle
        d0 = done_seen;
        run_req(0, 3, 0, 0, 4, n, oc);
        chk("model_oc_abort", oc, 3);
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_err", bus.err, 0);

        // req_valid held while busy (value changed mid-flight), then
        // accepted in the IDLE cycle right after DONE
        d0 = done_seen;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_value = 3'd6;
        bus.req_runs  = 4'd1;
        @(posedge clk); #1;
        predict(6, 1, 0, 0, -1, n1, oc1);
        predict(3, 1, 0, 0, -1, n2, oc2);
        push_trace(6, n1, oc1);
        push_idle(1'b0, 2'b00);
        push_trace(3, n2, oc2);
        bus.req_value = 3'd3;
        repeat (n1 + 3) @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_drain();
        chk("b2b_done_count", done_seen - d0, 2);

        // async reset mid-RUN
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_value = 3'd0;
        bus.req_runs  = 4'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        predict(0, 3, 0, 0, -1, n, oc);
        push_trace(0, n, oc);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        q.delete();
        idle_err  = 0;
        idle_code = 0;
        chk("midrst_ld_enb",    bus.ld_enb,    0);
        chk("midrst_count_enb", bus.count_enb, 0);
        chk("midrst_done",      bus.done,      0);
        chk("midrst_busy",      bus.busy,      0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_load_ctrl.md
Name: counter_load_ctrl

Overview:
- Master-side driver and checker for the loadable up-counter. Drives the counter's `ld_enb`, `data_in` and `count_enb`; monitors its `count_out` and `tc`.
- Accepts a request (preset value + number of terminal counts), loads the counter, and runs it until the requested number of terminal counts has been seen.
- Checks every counter cycle against an internal shadow model, then reports `done` or an error code.
- Sits between test/sequencer logic and the counter instance.

Parameters:
- WIDTH, 3, counter data width; must match the counter.
- RUNS_W, 4, width of the terminal-count request field.

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request valid.
- req_ready  output  1  high when a request can be accepted; equals (state==IDLE).
- req_value  input  WIDTH  preset value to load.
- req_runs  input  RUNS_W  number of tc events to observe; 0 is treated as 1.
- abort  input  1  cancel the current operation.
- ld_enb  output  1  counter load enable.
- data_in  output  WIDTH  counter load data.
- count_enb  output  1  counter count enable.
- count_out  input  WIDTH  counter value.
- tc  input  1  counter terminal count.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error flag.
- err_code  output  2  00 none, 01 value mismatch, 10 tc mismatch.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE.
  - ld_enb, count_enb, done, err = 0; err_code=00; data_in=0.
  - Internal registers exp and run_cnt cleared.
  - Reset mid-operation drops ld_enb and count_enb at once, with no done pulse.
- All outputs are registered or decoded from the state register only; no combinational path from input to output.
- Handshake: a transfer occurs on a rising edge with req_valid && req_ready.
  - The accepting edge captures req_value into exp and data_in, and max(req_runs,1) into run_tgt.
  - The same edge clears err/err_code, clears run_cnt, and moves state to LOAD.
  - req_valid while busy is ignored; the request is not queued.
- IDLE: ld_enb=0, count_enb=0.
- LOAD (exactly 1 cycle): ld_enb=1, count_enb=0, data_in=captured value. Next state RUN.
- RUN: count_enb=1, ld_enb=0. Every cycle, in priority order:
  1. abort=1 -> IDLE; err unchanged; no done.
  2. count_out != exp -> IDLE; err=1; err_code=01.
  3. tc != (count_out == all ones) -> IDLE; err=1; err_code=10.
  4. tc=1 and run_cnt+1 == run_tgt -> DONE.
  5. Otherwise stay in RUN; exp <= exp+1 (mod 2^WIDTH); run_cnt increments when tc=1.
- The first RUN cycle expects count_out == loaded value, since the counter loaded on the edge ending LOAD.
- DONE (1 cycle): done=1, count_enb=0, no checking. Next state IDLE.
  - The counter has wrapped to 0 on the edge into DONE and then holds.
- abort in LOAD -> IDLE. The counter has still loaded the value; this is acceptable.
- Error is sticky until the next accepted request or reset. Abort has priority over error detection in the same cycle.
- A new request may be accepted in the IDLE cycle immediately following DONE.
- run_cnt saturation: impossible, since the request completes when run_cnt reaches run_tgt <= 2^RUNS_W-1.

Test Plan:
- Reset, then req_value=5, req_runs=1:
  - ld_enb=1 with data_in=5 for one cycle.
  - RUN observes count_out 5,6,7 with tc=1 at 7.
  - done=1 in the next cycle; err=0; busy drops the cycle after.
- req_value=7, req_runs=2:
  - RUN sees 7(tc),0,1,…,7(tc), i.e. 9 RUN cycles.
  - Single done pulse; count_out=0 after DONE.
- req_value=0, req_runs=0: behaves as runs=1, with 8 RUN cycles before DONE.
- Counter output forced stuck at 2 in RUN after load value 1:
  - On the cycle exp=3, err=1 with err_code=01.
  - count_enb=0 next cycle; no done.
- tc forced to 0 while count_out=7 -> err_code=10; the next accepted request clears err.
- abort during RUN, and separately async rst asserted mid-RUN:
  - Abort -> IDLE, no done, err=0.
  - Reset -> ld_enb/count_enb=0 immediately.
- req_valid held high while busy is ignored; a back-to-back request is accepted in the IDLE cycle right after DONE.
